// File: rtl/axi_lite_slave.sv
// AXI4-lite slave bridging a single outstanding transaction onto a simple
// strobe-based user register port (write: rdy/ack, read: req/rdy).
module axi_lite_slave #(
   parameter int ADDR_WIDTH   = 32,
   parameter int DATA_WIDTH   = 32,
   parameter int STROBE_WIDTH = DATA_WIDTH / 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    i_awvalid,
   input  logic [ADDR_WIDTH-1:0]   i_awaddr,
   output logic                    o_awready,
   input  logic                    i_wvalid,
   output logic                    o_wready,
   input  logic [STROBE_WIDTH-1:0] i_wstrb,
   input  logic [DATA_WIDTH-1:0]   i_wdata,
   output logic                    o_bvalid,
   input  logic                    i_bready,
   output logic [1:0]              o_bresp,
   input  logic                    i_arvalid,
   output logic                    o_arready,
   input  logic [ADDR_WIDTH-1:0]   i_araddr,
   output logic                    o_rvalid,
   input  logic                    i_rready,
   output logic [1:0]              o_rresp,
   output logic [DATA_WIDTH-1:0]   o_rdata,
   output logic [ADDR_WIDTH-1:0]   o_reg_address,
   input  logic                    i_reg_invalid_addr,
   output logic                    o_reg_in_rdy,
   input  logic                    i_reg_in_ack_stb,
   output logic [DATA_WIDTH-1:0]   o_reg_in_data,
   output logic                    o_reg_out_req,
   input  logic                    i_reg_out_rdy_stb,
   input  logic [DATA_WIDTH-1:0]   i_reg_out_data
);

   typedef enum logic [2:0] {
      IDLE,
      WR_COLLECT,
      WR_REG,
      WR_RESP,
      RD_REG,
      RD_RESP
   } stateType;

   stateType                state_q, state_d;
   logic                    awBuf_q, awBuf_d;
   logic                    wBuf_q, wBuf_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [DATA_WIDTH-1:0]   wData_q, wData_d;
   logic [DATA_WIDTH-1:0]   rData_q, rData_d;
   logic [1:0]              bResp_q, bResp_d;
   logic [1:0]              rResp_q, rResp_d;

   // Full-word writes only, so the strobes are intentionally discarded.
   logic unusedWstrb;
   assign unusedWstrb = ^i_wstrb;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         awBuf_q <= 1'b0;
         wBuf_q  <= 1'b0;
         addr_q  <= '0;
         wData_q <= '0;
         rData_q <= '0;
         bResp_q <= 2'b00;
         rResp_q <= 2'b00;
      end else begin
         state_q <= state_d;
         awBuf_q <= awBuf_d;
         wBuf_q  <= wBuf_d;
         addr_q  <= addr_d;
         wData_q <= wData_d;
         rData_q <= rData_d;
         bResp_q <= bResp_d;
         rResp_q <= rResp_d;
      end
   end

   // The address register is shared: writes and reads never overlap.
   always_comb begin
      state_d = state_q;
      awBuf_d = awBuf_q;
      wBuf_d  = wBuf_q;
      addr_d  = addr_q;
      wData_d = wData_q;
      rData_d = rData_q;
      bResp_d = bResp_q;
      rResp_d = rResp_q;
      case (state_q)
         IDLE, WR_COLLECT: begin
            if (o_awready && i_awvalid) begin
               awBuf_d = 1'b1;
               addr_d  = i_awaddr;
            end
            if (o_wready && i_wvalid) begin
               wBuf_d  = 1'b1;
               wData_d = i_wdata;
            end
            if (awBuf_d && wBuf_d) begin
               state_d = WR_REG;
            end else if (awBuf_d || wBuf_d) begin
               state_d = WR_COLLECT;
            end else if (o_arready && i_arvalid) begin
               addr_d  = i_araddr;
               state_d = RD_REG;
            end
         end
         WR_REG: begin
            if (i_reg_in_ack_stb) begin
               bResp_d = i_reg_invalid_addr ? 2'b10 : 2'b00;
               state_d = WR_RESP;
            end
         end
         WR_RESP: begin
            if (i_bready) begin
               awBuf_d = 1'b0;
               wBuf_d  = 1'b0;
               state_d = IDLE;
            end
         end
         RD_REG: begin
            if (i_reg_out_rdy_stb) begin
               rData_d = i_reg_out_data;
               rResp_d = i_reg_invalid_addr ? 2'b10 : 2'b00;
               state_d = RD_RESP;
            end
         end
         RD_RESP: begin
            if (i_rready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Readies are gated by reset so every output reads zero while held in reset.
   always_comb begin
      o_awready     = 1'b0;
      o_wready      = 1'b0;
      o_arready     = 1'b0;
      o_bvalid      = 1'b0;
      o_rvalid      = 1'b0;
      o_reg_in_rdy  = 1'b0;
      o_reg_out_req = 1'b0;
      o_bresp       = bResp_q;
      o_rresp       = rResp_q;
      o_rdata       = rData_q;
      o_reg_address = addr_q;
      o_reg_in_data = wData_q;
      if (rst) begin
         o_awready     = (state_q == IDLE || state_q == WR_COLLECT) && !awBuf_q;
         o_wready      = (state_q == IDLE || state_q == WR_COLLECT) && !wBuf_q;
         o_arready     = (state_q == IDLE) && !awBuf_q && !wBuf_q && !i_awvalid && !i_wvalid;
         o_bvalid      = (state_q == WR_RESP);
         o_rvalid      = (state_q == RD_RESP);
         o_reg_in_rdy  = (state_q == WR_REG);
         o_reg_out_req = (state_q == RD_REG);
      end
   end

endmodule

// File: tb/tb_axi_lite_slave.sv
// Scoreboard bench for axi_lite_slave: the bench plays both the AXI master
// and the user register block, pushing expected results as it drives stimulus.
module tb_axi_lite_slave;

   logic        clk;
   logic        rst;
   logic        i_awvalid;
   logic [31:0] i_awaddr;
   logic        o_awready;
   logic        i_wvalid;
   logic        o_wready;
   logic [3:0]  i_wstrb;
   logic [31:0] i_wdata;
   logic        o_bvalid;
   logic        i_bready;
   logic [1:0]  o_bresp;
   logic        i_arvalid;
   logic        o_arready;
   logic [31:0] i_araddr;
   logic        o_rvalid;
   logic        i_rready;
   logic [1:0]  o_rresp;
   logic [31:0] o_rdata;
   logic [31:0] o_reg_address;
   logic        i_reg_invalid_addr;
   logic        o_reg_in_rdy;
   logic        i_reg_in_ack_stb;
   logic [31:0] o_reg_in_data;
   logic        o_reg_out_req;
   logic        i_reg_out_rdy_stb;
   logic [31:0] i_reg_out_data;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic [1:0]  resp;
   } txnType;

   txnType expWrQ[$];
   txnType expRdQ[$];

   int checkCount = 0;
   int errorCount = 0;
   int overlapCount = 0;

   axi_lite_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STROBE_WIDTH(4)) dut (
      .clk(clk), .rst(rst),
      .i_awvalid(i_awvalid), .i_awaddr(i_awaddr), .o_awready(o_awready),
      .i_wvalid(i_wvalid), .o_wready(o_wready), .i_wstrb(i_wstrb), .i_wdata(i_wdata),
      .o_bvalid(o_bvalid), .i_bready(i_bready), .o_bresp(o_bresp),
      .i_arvalid(i_arvalid), .o_arready(o_arready), .i_araddr(i_araddr),
      .o_rvalid(o_rvalid), .i_rready(i_rready), .o_rresp(o_rresp), .o_rdata(o_rdata),
      .o_reg_address(o_reg_address), .i_reg_invalid_addr(i_reg_invalid_addr),
      .o_reg_in_rdy(o_reg_in_rdy), .i_reg_in_ack_stb(i_reg_in_ack_stb),
      .o_reg_in_data(o_reg_in_data),
      .o_reg_out_req(o_reg_out_req), .i_reg_out_rdy_stb(i_reg_out_rdy_stb),
      .i_reg_out_data(i_reg_out_data)
   );

   // Free-running 10-unit clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // The user-side request strobes must never be high together.
   always @(negedge clk) begin
      if (o_reg_in_rdy && o_reg_out_req) overlapCount++;
   end

   // Hard stop in case something hangs outside the bounded waits.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Master and user side of one write; W and AW start on independent cycles.
   task automatic writeTxn(input logic [31:0] addr, input logic [31:0] data, input logic invalid,
                           input int awStart, input int wStart, input int breadyHold);
      txnType item;
      txnType got;
      bit awDone = 0;
      bit wDone = 0;
      bit awHs;
      bit wHs;
      int cyc = 0;
      item.addr = addr;
      item.data = data;
      item.resp = invalid ? 2'b10 : 2'b00;
      expWrQ.push_back(item);
      while (!(awDone && wDone) && cyc < 50) begin
         i_awvalid = !awDone && (cyc >= awStart);
         i_awaddr  = addr;
         i_wvalid  = !wDone && (cyc >= wStart);
         i_wdata   = data;
         i_wstrb   = 4'hF;
         checkOutput("no_early_reg_in_rdy", 64'(o_reg_in_rdy), 64'd0);
         if (wDone) checkOutput("wready_while_buffered", 64'(o_wready), 64'd0);
         awHs = i_awvalid && o_awready;
         wHs  = i_wvalid && o_wready;
         tick();
         if (awHs) awDone = 1;
         if (wHs) wDone = 1;
         cyc++;
      end
      i_awvalid = 1'b0;
      i_wvalid  = 1'b0;
      checkOutput("wr_accept_timeout", 64'(awDone && wDone), 64'd1);
      cyc = 0;
      while (!o_reg_in_rdy && cyc < 20) begin
         tick();
         cyc++;
      end
      checkOutput("reg_in_rdy_timeout", 64'(o_reg_in_rdy), 64'd1);
      got = expWrQ.pop_front();
      checkOutput("reg_in_addr", 64'(o_reg_address), 64'(got.addr));
      checkOutput("reg_in_data", 64'(o_reg_in_data), 64'(got.data));
      checkOutput("arready_during_write", 64'(o_arready), 64'd0);
      i_reg_in_ack_stb   = 1'b1;
      i_reg_invalid_addr = invalid;
      tick();
      i_reg_in_ack_stb   = 1'b0;
      i_reg_invalid_addr = 1'b0;
      cyc = 0;
      while (!o_bvalid && cyc < 20) begin
         tick();
         cyc++;
      end
      checkOutput("bvalid_timeout", 64'(o_bvalid), 64'd1);
      checkOutput("bresp", 64'(o_bresp), 64'(got.resp));
      for (int i = 0; i < breadyHold; i++) begin
         tick();
         checkOutput("bvalid_held", 64'(o_bvalid), 64'd1);
         checkOutput("bresp_held", 64'(o_bresp), 64'(got.resp));
      end
      i_bready = 1'b1;
      tick();
      i_bready = 1'b0;
      checkOutput("bvalid_cleared", 64'(o_bvalid), 64'd0);
   endtask

   // Master and user side of one read; the user returns userData.
   task automatic readTxn(input logic [31:0] addr, input logic [31:0] userData, input logic invalid);
      txnType item;
      txnType got;
      bit arHs = 0;
      int cyc = 0;
      item.addr = addr;
      item.data = userData;
      item.resp = invalid ? 2'b10 : 2'b00;
      expRdQ.push_back(item);
      i_arvalid = 1'b1;
      i_araddr  = addr;
      while (!arHs && cyc < 50) begin
         arHs = o_arready;
         tick();
         cyc++;
      end
      i_arvalid = 1'b0;
      checkOutput("ar_accept_timeout", 64'(arHs), 64'd1);
      cyc = 0;
      while (!o_reg_out_req && cyc < 20) begin
         tick();
         cyc++;
      end
      checkOutput("reg_out_req_timeout", 64'(o_reg_out_req), 64'd1);
      got = expRdQ.pop_front();
      checkOutput("reg_out_addr", 64'(o_reg_address), 64'(got.addr));
      i_reg_out_rdy_stb  = 1'b1;
      i_reg_out_data     = userData;
      i_reg_invalid_addr = invalid;
      tick();
      i_reg_out_rdy_stb  = 1'b0;
      i_reg_out_data     = 32'hA5A5_5A5A;
      i_reg_invalid_addr = 1'b0;
      cyc = 0;
      while (!o_rvalid && cyc < 20) begin
         tick();
         cyc++;
      end
      checkOutput("rvalid_timeout", 64'(o_rvalid), 64'd1);
      for (int i = 0; i < 2; i++) begin
         checkOutput("rdata", 64'(o_rdata), 64'(got.data));
         checkOutput("rresp", 64'(o_rresp), 64'(got.resp));
         tick();
      end
      checkOutput("rvalid_held", 64'(o_rvalid), 64'd1);
      i_rready = 1'b1;
      tick();
      i_rready = 1'b0;
      checkOutput("rvalid_cleared", 64'(o_rvalid), 64'd0);
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_data"}, {o_rdata, o_reg_address}, 64'd0);
      checkOutput({tag, "_indata"}, 64'(o_reg_in_data), 64'd0);
      checkOutput({tag, "_ctrl"}, 64'({o_awready, o_wready, o_bvalid, o_arready, o_rvalid,
                                       o_reg_in_rdy, o_reg_out_req, o_bresp, o_rresp}), 64'd0);
   endtask

   task automatic applyStimulus();
      // Reset with requests pending: readies must still read zero.
      rst = 1'b0;
      i_awvalid = 1'b1; i_awaddr = 32'h0; i_wvalid = 1'b1; i_wdata = 32'h0; i_wstrb = 4'h0;
      i_bready = 1'b0; i_arvalid = 1'b1; i_araddr = 32'h0; i_rready = 1'b0;
      i_reg_invalid_addr = 1'b0; i_reg_in_ack_stb = 1'b0;
      i_reg_out_rdy_stb = 1'b0; i_reg_out_data = 32'h0;
      tick();
      tick();
      checkAllZero("reset");
      i_awvalid = 1'b0; i_wvalid = 1'b0; i_arvalid = 1'b0;
      rst = 1'b1;
      tick();
      checkOutput("idle_awready", 64'(o_awready), 64'd1);
      checkOutput("idle_arready", 64'(o_arready), 64'd1);

      // AW and W together, valid address.
      writeTxn(32'h0, 32'h1234_5678, 1'b0, 0, 0, 0);
      readTxn(32'h4, 32'h1000_0000, 1'b0);

      // Invalid address reported by the user.
      writeTxn(32'h8, 32'hDEAD_BEEF, 1'b1, 0, 0, 1);
      readTxn(32'h8, 32'h0000_0000, 1'b1);

      // W three cycles ahead of AW, slow response acceptance; then AW first.
      writeTxn(32'h10, 32'hCAFE_F00D, 1'b0, 3, 0, 5);
      writeTxn(32'h14, 32'h0BAD_F00D, 1'b0, 0, 2, 0);

      // Stray strobes while idle must not start or complete anything.
      i_reg_in_ack_stb = 1'b1; i_reg_out_rdy_stb = 1'b1; i_reg_invalid_addr = 1'b1;
      tick();
      i_reg_in_ack_stb = 1'b0; i_reg_out_rdy_stb = 1'b0; i_reg_invalid_addr = 1'b0;
      checkOutput("stray_strobe", 64'({o_bvalid, o_rvalid, o_reg_in_rdy, o_reg_out_req, o_awready}), 64'd1);

      // Simultaneous write and read request: write wins, read follows.
      i_arvalid = 1'b1;
      i_araddr  = 32'h20;
      writeTxn(32'h1C, 32'h5555_AAAA, 1'b0, 0, 0, 0);
      readTxn(32'h20, 32'h7777_0001, 1'b0);

      // Reset in the middle of a read aborts it.
      i_arvalid = 1'b1;
      i_araddr  = 32'hC;
      tick();
      i_arvalid = 1'b0;
      checkOutput("abort_reg_out_req", 64'(o_reg_out_req), 64'd1);
      rst = 1'b0;
      #1;
      checkAllZero("midreset");
      tick();
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checkOutput("no_resp_after_reset", 64'({o_bvalid, o_rvalid, o_reg_out_req, o_reg_in_rdy}), 64'd0);
      end
      writeTxn(32'h30, 32'h0102_0304, 1'b0, 0, 0, 0);
   endtask

   initial begin
      applyStimulus();
      checkOutput("no_overlap", 64'(overlapCount), 64'd0);
      checkOutput("scoreboard_empty", 64'(expWrQ.size() + expRdQ.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule
